// File: rtl/lcd_frame_streamer.sv
// 2x16 character buffer feeding an HD44780 byte engine: on any change it streams one frame of
// {is_data, byte} beats. Forced periodic redraw when LCD_FRAME_STREAMER_AUTO_REFRESH_EN is defined.
module lcd_frame_streamer #(
    parameter int          COLS        = 16,
    parameter int          ROWS        = 2,
    parameter logic [7:0]  ROW1_BASE   = 8'h40,
    parameter int unsigned REFRESH_CYC = 5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       init_done,
    output logic       out_valid,
    output logic       out_is_data,
    output logic [7:0] out_byte,
    input  logic       out_ready,
    output logic       busy,
    output logic       frame_done
);
    localparam logic [4:0] COLS_LIM = 5'(COLS);
    localparam logic [1:0] ROWS_LIM = 2'(ROWS);
    localparam logic [3:0] LAST_COL = 4'(COLS - 1);
    localparam logic       LAST_ROW = 1'(ROWS - 1);
    localparam logic [7:0] CMD_ROW0 = 8'h80;
    localparam logic [7:0] CMD_ROW1 = 8'h80 | ROW1_BASE;

    typedef enum logic [1:0] {S_IDLE, S_ROWCMD, S_CHAR, S_FIN} state_t;

    state_t     state, state_next;
    logic [7:0] cells [2][16];
    logic       dirty, dirty_next;
    logic       row, row_next;
    logic [3:0] col, col_next, col_inc;
    logic       valid_next, is_data_next, busy_next, done_next;
    logic [7:0] byte_next;
    logic       wr_ok, accept, start, refresh_hit;

    assign wr_ok   = wr_en && ({1'b0, wr_addr[4]} < ROWS_LIM) && ({1'b0, wr_addr[3:0]} < COLS_LIM);
    assign accept  = out_valid && out_ready;
    assign start   = (state == S_IDLE) && dirty && init_done;
    assign col_inc = col + 4'd1;

    // NOTE: the buffer sits in the async reset so the display powers up blank; this keeps it in flops, not RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 2; r++)
                for (int c = 0; c < 16; c++)
                    cells[r][c] <= 8'h20;
        end else if (wr_ok) begin
            cells[wr_addr[4]][wr_addr[3:0]] <= wr_data;
        end
    end

`ifdef LCD_FRAME_STREAMER_AUTO_REFRESH_EN
    logic [31:0] idle_cnt;
    logic        idle_wrap;

    assign idle_wrap   = (state == S_IDLE) && (idle_cnt == 32'(REFRESH_CYC - 1));
    assign refresh_hit = idle_wrap && !start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            idle_cnt <= 32'd0;
        else if ((state != S_IDLE) || idle_wrap)
            idle_cnt <= 32'd0;
        else
            idle_cnt <= idle_cnt + 32'd1;
    end
`else
    assign refresh_hit = 1'b0;
`endif

    // A write landing in the start cycle must keep dirty set, so it is applied last.
    always_comb begin
        dirty_next = dirty;
        if (start)
            dirty_next = 1'b0;
        if (refresh_hit || wr_ok)
            dirty_next = 1'b1;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next   = state;
        row_next     = row;
        col_next     = col;
        valid_next   = out_valid;
        is_data_next = out_is_data;
        byte_next    = out_byte;
        busy_next    = busy;
        done_next    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (dirty && init_done) begin
                    row_next     = 1'b0;
                    col_next     = 4'd0;
                    byte_next    = CMD_ROW0;
                    is_data_next = 1'b0;
                    valid_next   = 1'b1;
                    busy_next    = 1'b1;
                    state_next   = S_ROWCMD;
                end
            end
            S_ROWCMD: begin
                if (accept) begin
                    byte_next    = cells[row][4'd0];
                    is_data_next = 1'b1;
                    state_next   = S_CHAR;
                end
            end
            S_CHAR: begin
                if (accept) begin
                    if (col < LAST_COL) begin
                        col_next  = col_inc;
                        byte_next = cells[row][col_inc];
                    end else if (row < LAST_ROW) begin
                        row_next     = 1'b1;
                        col_next     = 4'd0;
                        byte_next    = CMD_ROW1;
                        is_data_next = 1'b0;
                        state_next   = S_ROWCMD;
                    end else begin
                        valid_next = 1'b0;
                        done_next  = 1'b1;
                        state_next = S_FIN;
                    end
                end
            end
            S_FIN: begin
                busy_next  = 1'b0;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            dirty       <= 1'b1;
            row         <= 1'b0;
            col         <= 4'd0;
            out_valid   <= 1'b0;
            out_is_data <= 1'b0;
            out_byte    <= 8'h00;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_next;
            dirty       <= dirty_next;
            row         <= row_next;
            col         <= col_next;
            out_valid   <= valid_next;
            out_is_data <= is_data_next;
            out_byte    <= byte_next;
            busy        <= busy_next;
            frame_done  <= done_next;
        end
    end

endmodule

// File: tb/tb_lcd_frame_streamer.sv
// Directed bench for lcd_frame_streamer: frames are captured beat by beat and compared
// against a buffer model; also covers stalls, mid-frame writes, init gating, reset and refresh.
`timescale 1ns/1ps
module tb_lcd_frame_streamer;
    localparam int REFRESH = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       init_done;
    logic       out_valid;
    logic       out_is_data;
    logic [7:0] out_byte;
    logic       out_ready;
    logic       busy;
    logic       frame_done;

    always #5 clk = ~clk;

    lcd_frame_streamer #(
        .COLS(16), .ROWS(2), .ROW1_BASE(8'h40), .REFRESH_CYC(REFRESH)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .init_done(init_done), .out_valid(out_valid), .out_is_data(out_is_data),
        .out_byte(out_byte), .out_ready(out_ready), .busy(busy), .frame_done(frame_done)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] model [2][16];
    logic [8:0] beats [64];
    int         nbeats;
    int         done_cyc;
    bit         got_done;
    bit         stable_ok;
    bit         busy_ok;
    bit         seen_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_blank();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 16; c++)
                model[r][c] = 8'h20;
    endtask

    task automatic write_cell(input logic [4:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
        model[a[4]][a[3:0]] = d;
    endtask

    // Runs until frame_done (or budget), capturing accepted beats; optionally injects one write
    // while beat inj_beat is pending. Returns one cycle after the frame_done cycle.
    task automatic run_frame(input int pct, input int budget, input int inj_beat,
                             input logic [4:0] inj_addr, input logic [7:0] inj_data);
        bit         held;
        bit         injected;
        logic [8:0] held_beat;
        nbeats = 0; got_done = 0; done_cyc = -1; stable_ok = 1; busy_ok = 1;
        held = 0; injected = 0; held_beat = '0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            wr_en = 1'b0;
            if (held && (!out_valid || ({out_is_data, out_byte} !== held_beat)))
                stable_ok = 0;
            if (frame_done) begin
                got_done = 1;
                done_cyc = cyc;
                break;
            end
            if (out_valid && !busy)
                busy_ok = 0;
            out_ready = (int'($urandom_range(99)) < pct);
            if (out_valid && (nbeats == inj_beat) && !injected) begin
                wr_en = 1'b1; wr_addr = inj_addr; wr_data = inj_data;
                injected = 1;
            end
            if (out_valid && out_ready) begin
                if (nbeats < 64)
                    beats[nbeats] = {out_is_data, out_byte};
                nbeats++;
            end
            held      = out_valid && !out_ready;
            held_beat = {out_is_data, out_byte};
            tick();
        end
        wr_en     = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic check_frame(input string tag);
        int         k;
        logic [8:0] exp;
        check({tag, "_done"}, 32'(got_done), 32'd1);
        check({tag, "_beats"}, nbeats, 34);
        check({tag, "_stall_stable"}, 32'(stable_ok), 32'd1);
        check({tag, "_busy"}, 32'(busy_ok), 32'd1);
        k = 0;
        for (int r = 0; r < 2; r++) begin
            exp = (r == 0) ? 9'h080 : 9'h0C0;
            check($sformatf("%s_beat%0d", tag, k), 32'(beats[k]), 32'(exp));
            k++;
            for (int c = 0; c < 16; c++) begin
                exp = {1'b1, model[r][c]};
                check($sformatf("%s_beat%0d", tag, k), 32'(beats[k]), 32'(exp));
                k++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        init_done = 1'b1; out_ready = 1'b1;
        model_blank();
        repeat (3) tick();

        // Reset state
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_is_data", 32'(out_is_data), 32'd0);
        check("rst_byte", 32'(out_byte), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);

        // 1: post-reset frame of blanks, frame_done on cycle 35
        rst = 1'b0;
        run_frame(100, 200, -1, 5'h00, 8'h00);
        check_frame("t1");
        check("t1_latency", done_cyc, 35);
        check("t1_busy_after", 32'(busy), 32'd0);
        repeat (5) tick();
        check("t1_no_repeat", 32'(out_valid), 32'd0);

        // 2: one write (row 1, col 3) -> one frame with data 41 at beat 18+3
        write_cell(5'h13, 8'h41);
        run_frame(100, 200, -1, 5'h00, 8'h00);
        check_frame("t2");
        check("t2_beat21", 32'(beats[21]), 32'h141);
        check("t2_latency", done_cyc, 35);

        // 3: 50% backpressure, last cell written
        write_cell(5'h1F, 8'h7E);
        run_frame(50, 400, -1, 5'h00, 8'h00);
        check_frame("t3");

        // 4: write to an already-sent cell during beat 25 -> pending frame unchanged, second frame follows
        write_cell(5'h0F, 8'h39);
        run_frame(100, 200, 25, 5'h02, 8'h5A);
        check_frame("t4a");
        check("t4a_beat3", 32'(beats[3]), 32'h120);
        model[0][2] = 8'h5A;
        run_frame(100, 200, -1, 5'h00, 8'h00);
        check_frame("t4b");
        check("t4b_beat3", 32'(beats[3]), 32'h15A);
        check("t4b_latency", done_cyc, 35);

        // 5: init_done low for 1000 cycles with writes -> silent; then one frame
        init_done = 1'b0;
        seen_valid = 0;
        for (int i = 0; i < 1000; i++) begin
            if (i == 100)
                write_cell(5'h00, 8'h48);
            else if (i == 900)
                write_cell(5'h1A, 8'h5B);
            else
                tick();
            if (out_valid)
                seen_valid = 1;
        end
        check("t5_quiet", 32'(seen_valid), 32'd0);
        init_done = 1'b1;
        run_frame(100, 200, -1, 5'h00, 8'h00);
        check_frame("t5");
        check("t5_latency", done_cyc, 35);

        // 7: async reset mid-frame drops the beat and the buffer
        write_cell(5'h01, 8'h42);
        repeat (10) tick();
        check("t7_valid_before", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t7_valid_drop", 32'(out_valid), 32'd0);
        check("t7_busy_drop", 32'(busy), 32'd0);
        check("t7_no_done", 32'(frame_done), 32'd0);
        tick();
        rst = 1'b0;
        model_blank();
        run_frame(100, 200, -1, 5'h00, 8'h00);
        check_frame("t7");
        check("t7_latency", done_cyc, 35);

        // 6: idle with no writes
`ifdef LCD_FRAME_STREAMER_AUTO_REFRESH_EN
        run_frame(100, 300, -1, 5'h00, 8'h00);
        check_frame("t6");
        check("t6_refresh_gap", done_cyc, 135);
`else
        run_frame(100, 300, -1, 5'h00, 8'h00);
        check("t6_no_refresh_beats", nbeats, 0);
        check("t6_no_refresh_done", 32'(got_done), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
